// File: rtl/weight_packer.sv
// weight_packer: gathers a byte-wide weight stream into LANES-wide words and
// writes them into the weight_router SRAM. Writes start at a programmable base
// address. A partial final word is zero-padded. A one-cycle done pulse follows
// the last write.
module weight_packer #(
  parameter int DATA_WIDTH  = 8,
  parameter int LANES       = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int COUNT_WIDTH = 12
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_start,
  input  logic [ADDR_WIDTH-1:0]       i_base_addr,
  input  logic [COUNT_WIDTH-1:0]      i_count,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_sram_write_en,
  output logic [ADDR_WIDTH-1:0]       o_sram_write_addr,
  output logic [DATA_WIDTH*LANES-1:0] o_sram_data,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int WORD_W = DATA_WIDTH * LANES;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [LANE_W-1:0]      lane;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [WORD_W-1:0]      pack_buf;

  logic                   accept;
  logic                   word_full;
  logic                   last_byte;
  logic [WORD_W-1:0]      merged;

  // A byte is consumed only while packing; o_ready is a pure function of state.
  assign accept    = (state == S_PACK) && i_valid;
  assign last_byte = (remaining == COUNT_WIDTH'(1));
  assign word_full = (lane == LANE_W'(LANES - 1)) || last_byte;

  // Current buffer with the incoming byte dropped into its lane; unfilled lanes stay 0.
  always_comb begin
    merged = pack_buf;
    merged[int'(lane) * DATA_WIDTH +: DATA_WIDTH] = i_data;
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs; clear overrides every transition.
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_nxt = (i_count != '0) ? S_PACK : S_DONE;
      end
      S_PACK: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        if (accept && last_byte) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        o_busy    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (i_clear) state_nxt = S_IDLE;
  end

  // Packing datapath and registered SRAM write port; strobe, address and data are 0 except in a write cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lane              <= '0;
      remaining         <= '0;
      addr              <= '0;
      pack_buf          <= '0;
      o_sram_write_en   <= 1'b0;
      o_sram_write_addr <= '0;
      o_sram_data       <= '0;
    end else if (i_clear) begin
      lane              <= '0;
      remaining         <= '0;
      addr              <= '0;
      pack_buf          <= '0;
      o_sram_write_en   <= 1'b0;
      o_sram_write_addr <= '0;
      o_sram_data       <= '0;
    end else begin
      o_sram_write_en   <= 1'b0;
      o_sram_write_addr <= '0;
      o_sram_data       <= '0;
      if (state == S_IDLE && i_start) begin
        addr      <= i_base_addr;
        remaining <= i_count;
        lane      <= '0;
        pack_buf  <= '0;
      end else if (accept) begin
        remaining <= remaining - COUNT_WIDTH'(1);
        if (word_full) begin
          o_sram_write_en   <= 1'b1;
          o_sram_write_addr <= addr;
          o_sram_data       <= merged;
          addr              <= addr + ADDR_WIDTH'(1);
          lane              <= '0;
          pack_buf          <= '0;
        end else begin
          lane     <= lane + LANE_W'(1);
          pack_buf <= merged;
        end
      end
    end
  end

endmodule
